// File: rtl/con_sequencer.sv
// Control sequencer for a small accumulator-style CPU: fetch/execute FSM that
// decodes the instruction register into datapath strobes with handshake stalls.
module con_sequencer #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ir,
    input  logic              z,
    input  logic              c,
    input  logic              mem_ready,
    input  logic              in_valid,
    input  logic              out_ready,
    input  logic              step_mode,
    input  logic              step,
    output logic [REG_AW-1:0] reg_ra,
    output logic [REG_AW-1:0] reg_wa,
    output logic [1:0]        madd,
    output logic [3:0]        alu_s,
    output logic              pc_ld,
    output logic              pc_inc,
    output logic              ir_ld,
    output logic              ram_dl,
    output logic              ram_xl,
    output logic              alu_m,
    output logic              cf_en,
    output logic              zf_en,
    output logic              shi_fbus,
    output logic              shi_frbus,
    output logic              shi_flbus,
    output logic              in_en,
    output logic              out_en,
    output logic              reg_we,
    output logic              halted,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_PAUSE = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVA = 4'h1;
    localparam logic [3:0] OP_MOVB = 4'h2;
    localparam logic [3:0] OP_MOVC = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_RSR  = 4'h8;
    localparam logic [3:0] OP_RSL  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_IN   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state_q, state_d;
    logic              step_pend_q;
    logic [CNT_W-1:0]  retired_q;
    logic              z_q, c_q;
    logic              exec_cont_q;
    logic              exec_done;
    logic              z_eff, c_eff;
    logic              jump_taken;
    logic [3:0]        opcode;

    assign opcode  = ir[DATA_W-1 -: 4];
    assign reg_ra  = ir[REG_AW-1:0];
    assign reg_wa  = ir[2*REG_AW-1:REG_AW];
    assign alu_s   = opcode;
    assign state   = state_q;
    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;

    // Flags are live in the first EXEC cycle and frozen for any stall cycles after it
    assign z_eff = exec_cont_q ? z_q : z;
    assign c_eff = exec_cont_q ? c_q : c;
    assign jump_taken = (opcode == OP_JMP) ||
                        ((opcode == OP_JZ) && z_eff) ||
                        ((opcode == OP_JC) && c_eff);

    always_comb begin
        state_d   = state_q;
        exec_done = 1'b0;
        madd      = 2'b00;
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        ir_ld     = 1'b0;
        ram_dl    = 1'b0;
        ram_xl    = 1'b0;
        alu_m     = 1'b0;
        cf_en     = 1'b0;
        zf_en     = 1'b0;
        shi_fbus  = 1'b0;
        shi_frbus = 1'b0;
        shi_flbus = 1'b0;
        in_en     = 1'b0;
        out_en    = 1'b0;
        reg_we    = 1'b1;

        case (state_q)
            ST_RST: begin
                state_d = step_mode ? ST_PAUSE : ST_FETCH;
            end
            ST_PAUSE: begin
                if (step_pend_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ram_dl = 1'b1;
                if (mem_ready) begin
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_NOP, OP_HALT: exec_done = 1'b1;
                    OP_MOVA: begin
                        shi_fbus  = 1'b1;
                        reg_we    = 1'b0;
                        exec_done = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        shi_fbus  = 1'b1;
                        alu_m     = 1'b1;
                        reg_we    = 1'b0;
                        cf_en     = 1'b1;
                        zf_en     = 1'b1;
                        exec_done = 1'b1;
                    end
                    OP_AND, OP_NOT: begin
                        shi_fbus  = 1'b1;
                        alu_m     = 1'b1;
                        reg_we    = 1'b0;
                        exec_done = 1'b1;
                    end
                    OP_RSR: begin
                        shi_frbus = 1'b1;
                        alu_m     = 1'b1;
                        reg_we    = 1'b0;
                        cf_en     = 1'b1;
                        exec_done = 1'b1;
                    end
                    OP_RSL: begin
                        shi_flbus = 1'b1;
                        alu_m     = 1'b1;
                        reg_we    = 1'b0;
                        cf_en     = 1'b1;
                        exec_done = 1'b1;
                    end
                    OP_MOVB: begin
                        madd      = 2'b10;
                        ram_xl    = 1'b1;
                        exec_done = mem_ready;
                    end
                    OP_MOVC: begin
                        madd      = 2'b01;
                        ram_dl    = 1'b1;
                        reg_we    = ~mem_ready;
                        exec_done = mem_ready;
                    end
                    OP_JMP, OP_JZ, OP_JC: begin
                        if (jump_taken) begin
                            ram_dl    = 1'b1;
                            pc_ld     = mem_ready;
                            exec_done = mem_ready;
                        end else begin
                            pc_inc    = 1'b1;
                            exec_done = 1'b1;
                        end
                    end
                    OP_IN: begin
                        in_en     = in_valid;
                        reg_we    = ~in_valid;
                        exec_done = in_valid;
                    end
                    OP_OUT: begin
                        alu_m     = 1'b1;
                        shi_fbus  = 1'b1;
                        out_en    = 1'b1;
                        exec_done = out_ready;
                    end
                    default: exec_done = 1'b1;
                endcase
                if (exec_done) begin
                    if (opcode == OP_HALT) state_d = ST_HALT;
                    else                   state_d = step_mode ? ST_PAUSE : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            step_pend_q <= 1'b0;
            retired_q   <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            exec_cont_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // A new step request wins over the clear issued when leaving PAUSE
            step_pend_q <= step ||
                           (step_pend_q && !((state_q == ST_PAUSE) && (state_d == ST_FETCH)));
            retired_q   <= retired_q + {{(CNT_W-1){1'b0}}, exec_done};
            exec_cont_q <= (state_q == ST_EXEC) && !exec_done;
            if ((state_q == ST_EXEC) && !exec_cont_q) begin
                z_q <= z;
                c_q <= c;
            end
        end
    end

endmodule

// File: tb/tb_con_sequencer.sv
// Bench for con_sequencer: directed scenarios with literal checks plus a
// rule-level reference model compared against every output on each cycle.
module tb_con_sequencer;

    localparam int DATA_W = 8;
    localparam int REG_AW = 2;
    localparam int CNT_W  = 4;

    logic              clk, rst_n;
    logic [DATA_W-1:0] ir;
    logic              z, c, mem_ready, in_valid, out_ready, step_mode, step;
    logic [REG_AW-1:0] reg_ra, reg_wa;
    logic [1:0]        madd;
    logic [3:0]        alu_s;
    logic              pc_ld, pc_inc, ir_ld, ram_dl, ram_xl, alu_m, cf_en, zf_en;
    logic              shi_fbus, shi_frbus, shi_flbus, in_en, out_en, reg_we, halted;
    logic [2:0]        state;
    logic [CNT_W-1:0]  retired;

    con_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .z(z), .c(c), .mem_ready(mem_ready),
        .in_valid(in_valid), .out_ready(out_ready), .step_mode(step_mode), .step(step),
        .reg_ra(reg_ra), .reg_wa(reg_wa), .madd(madd), .alu_s(alu_s),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld), .ram_dl(ram_dl), .ram_xl(ram_xl),
        .alu_m(alu_m), .cf_en(cf_en), .zf_en(zf_en), .shi_fbus(shi_fbus),
        .shi_frbus(shi_frbus), .shi_flbus(shi_flbus), .in_en(in_en), .out_en(out_en),
        .reg_we(reg_we), .halted(halted), .state(state), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bit positions within the packed strobe word
    localparam int B_PC_LD = 12, B_PC_INC = 11, B_IR_LD = 10, B_RAM_DL = 9, B_RAM_XL = 8;
    localparam int B_ALU_M = 7, B_CF = 6, B_ZF = 5, B_FBUS = 4, B_FR = 3, B_FL = 2;
    localparam int B_IN = 1, B_OUT = 0;

    logic [12:0] dut_stb;
    assign dut_stb = {pc_ld, pc_inc, ir_ld, ram_dl, ram_xl, alu_m, cf_en, zf_en,
                      shi_fbus, shi_frbus, shi_flbus, in_en, out_en};

    typedef struct packed {
        logic [12:0] stb;
        logic        we;
        logic [1:0]  madd;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: state names 0..4 as listed in the state table
    int               m_st;
    logic             m_pend, m_fresh, m_zh, m_ch;
    logic [CNT_W-1:0] m_ret;
    logic             m_z, m_c;
    logic [3:0]       m_op;

    assign m_z  = m_fresh ? z : m_zh;
    assign m_c  = m_fresh ? c : m_ch;
    assign m_op = ir[7:4];

    function automatic logic finishes(input logic [3:0] op, input logic zf, input logic cf,
                                      input logic mr, input logic iv, input logic ordy);
        logic taken;
        taken = (op == 4'hA) || (op == 4'hB && zf) || (op == 4'hC && cf);
        if (op == 4'h2 || op == 4'h3 || taken) return mr;
        if (op == 4'hD) return iv;
        if (op == 4'hE) return ordy;
        return 1'b1;
    endfunction

    function automatic exp_t expect_out(input int st, input logic [3:0] op, input logic zf,
                                        input logic cf, input logic mr, input logic iv,
                                        input logic ordy);
        exp_t e;
        logic taken;
        e = '0;
        e.we = 1'b1;
        taken = (op == 4'hA) || (op == 4'hB && zf) || (op == 4'hC && cf);
        if (st == 2) begin
            e.stb[B_RAM_DL] = 1'b1;
            e.stb[B_IR_LD]  = mr;
            e.stb[B_PC_INC] = mr;
        end else if (st == 3) begin
            if (op inside {4'h1, 4'h4, 4'h5, 4'h6, 4'h7}) begin
                e.stb[B_FBUS]  = 1'b1;
                e.stb[B_ALU_M] = (op != 4'h1);
                e.we = 1'b0;
            end
            if (op == 4'h8) begin e.stb[B_FR] = 1'b1; e.stb[B_ALU_M] = 1'b1; e.we = 1'b0; end
            if (op == 4'h9) begin e.stb[B_FL] = 1'b1; e.stb[B_ALU_M] = 1'b1; e.we = 1'b0; end
            e.stb[B_CF] = op inside {4'h4, 4'h5, 4'h8, 4'h9};
            e.stb[B_ZF] = op inside {4'h4, 4'h5};
            if (op == 4'h2) begin e.madd = 2'b10; e.stb[B_RAM_XL] = 1'b1; end
            if (op == 4'h3) begin e.madd = 2'b01; e.stb[B_RAM_DL] = 1'b1; e.we = ~mr; end
            if (taken) begin e.stb[B_RAM_DL] = 1'b1; e.stb[B_PC_LD] = mr; end
            if ((op == 4'hB || op == 4'hC) && !taken) e.stb[B_PC_INC] = 1'b1;
            if (op == 4'hD) begin e.stb[B_IN] = iv; e.we = ~iv; end
            if (op == 4'hE) begin
                e.stb[B_ALU_M] = 1'b1;
                e.stb[B_FBUS]  = 1'b1;
                e.stb[B_OUT]   = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_pend <= 1'b0; m_ret <= '0;
            m_fresh <= 1'b0; m_zh <= 1'b0; m_ch <= 1'b0;
        end else begin
            m_pend <= step ? 1'b1 : ((m_st == 1 && m_pend) ? 1'b0 : m_pend);
            case (m_st)
                0: m_st <= step_mode ? 1 : 2;
                1: if (m_pend) m_st <= 2;
                2: if (mem_ready) begin m_st <= 3; m_fresh <= 1'b1; end
                3: begin
                    if (m_fresh) begin m_zh <= z; m_ch <= c; m_fresh <= 1'b0; end
                    if (finishes(m_op, m_z, m_c, mem_ready, in_valid, out_ready)) begin
                        m_ret <= m_ret + CNT_W'(1);
                        m_st  <= (m_op == 4'hF) ? 4 : (step_mode ? 1 : 2);
                    end
                end
                4: m_st <= 4;
                default: m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = expect_out(m_st, m_op, m_z, m_c, mem_ready, in_valid, out_ready);
        chk("m_state",   32'(state),   32'(m_st));
        chk("m_strobes", 32'(dut_stb), 32'(e.stb));
        chk("m_reg_we",  32'(reg_we),  32'(e.we));
        chk("m_madd",    32'(madd),    32'(e.madd));
        chk("m_alu_s",   32'(alu_s),   32'(ir[7:4]));
        chk("m_reg_wa",  32'(reg_wa),  32'(ir[3:2]));
        chk("m_reg_ra",  32'(reg_ra),  32'(ir[1:0]));
        chk("m_halted",  32'(halted),  32'(m_st == 4));
        chk("m_retired", 32'(retired), 32'(m_ret));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim);
        int k;
        k = 0;
        while (state !== s && k < lim) begin
            cyc();
            k++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    initial begin
        rst_n = 1'b0; ir = 8'h46; z = 1'b0; c = 1'b0; mem_ready = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; step_mode = 1'b0; step = 1'b0;
        #2;
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_halted",  32'(halted),  32'd0);
        chk("rst_strobes", 32'(dut_stb), 32'd0);
        chk("rst_reg_we",  32'(reg_we),  32'd1);
        #10 rst_n = 1'b1;
        #1 chk("rel_state", 32'(state), 32'd0);

        // ADD 0x46
        cyc(); chk("add_fetch", 32'(state), 32'd2); chk("add_ir_ld", 32'(ir_ld), 32'd1);
        cyc();
        chk("add_exec",  32'(state),  32'd3);
        chk("add_we",    32'(reg_we), 32'd0);
        chk("add_alu_s", 32'(alu_s),  32'd4);
        chk("add_wa",    32'(reg_wa), 32'd1);
        chk("add_ra",    32'(reg_ra), 32'd2);
        chk("add_cfzf",  32'({cf_en, zf_en}), 32'd3);
        cyc(); chk("add_back", 32'(state), 32'd2); chk("add_ret", 32'(retired), 32'd1);

        // MOVC 0x30 with three stall cycles
        ir = 8'h30;
        cyc(); mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) mem_ready = 1'b1;
            #1;
            chk("movc_state", 32'(state),  32'd3);
            chk("movc_madd",  32'(madd),   32'd1);
            chk("movc_dl",    32'(ram_dl), 32'd1);
            chk("movc_we",    32'(reg_we), (i == 4) ? 32'd0 : 32'd1);
            cyc();
        end
        chk("movc_done", 32'(state), 32'd2); chk("movc_ret", 32'(retired), 32'd2);

        // JZ taken with z held across a stall, then untaken
        ir = 8'hB0; z = 1'b1;
        cyc(); mem_ready = 1'b0;
        #1 chk("jz_stall_ld", 32'({pc_ld, pc_inc, ram_dl}), 32'b001);
        cyc(); z = 1'b0; mem_ready = 1'b1;
        #1 chk("jz_taken", 32'({pc_ld, pc_inc}), 32'b10);
        cyc(); chk("jz_ret", 32'(retired), 32'd3);
        cyc(); chk("jz_untaken", 32'({pc_ld, pc_inc, ram_dl}), 32'b010);
        cyc(); chk("jz_single", 32'(state), 32'd2); chk("jz_ret2", 32'(retired), 32'd4);

        // Single-step mode
        ir = 8'h00; step_mode = 1'b1;
        cyc(); cyc();
        chk("step_pause", 32'(state), 32'd1); chk("step_ret", 32'(retired), 32'd5);
        repeat (5) begin
            cyc();
            chk("pause_hold", 32'(state), 32'd1);
            chk("pause_stb",  32'(dut_stb), 32'd0);
        end
        step = 1'b1; cyc(); step = 1'b0;
        chk("step_pend_wait", 32'(state), 32'd1);
        cyc(); chk("step_fetch", 32'(state), 32'd2);
        cyc(); chk("step_exec",  32'(state), 32'd3);
        cyc(); chk("step_back",  32'(state), 32'd1); chk("step_ret2", 32'(retired), 32'd6);
        repeat (3) cyc();
        chk("step_stay", 32'(state), 32'd1);

        // HALT
        ir = 8'hF0; step = 1'b1; cyc(); step = 1'b0;
        cyc(); cyc(); chk("halt_exec", 32'(state), 32'd3);
        cyc();
        chk("halt_state",  32'(state),   32'd4);
        chk("halt_flag",   32'(halted),  32'd1);
        chk("halt_ret",    32'(retired), 32'd7);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step      = 1'($urandom_range(0, 1));
            cyc();
            chk("halt_stb",  32'(dut_stb), 32'd0);
            chk("halt_stay", 32'(state),   32'd4);
        end
        rst_n = 1'b0; step = 1'b0;
        #1 chk("halt_reset", 32'(state), 32'd0); chk("halt_rst_flag", 32'(halted), 32'd0);

        // Counter wrap with CNT_W=4
        ir = 8'h00; mem_ready = 1'b1; step_mode = 1'b0;
        cyc(); rst_n = 1'b1;
        repeat (31) cyc();
        chk("wrap_15", 32'(retired), 32'd15); chk("wrap_st", 32'(state), 32'd2);
        repeat (2) cyc();
        chk("wrap_0", 32'(retired), 32'd0);

        // MOVB stall aborted by reset
        ir = 8'h20;
        cyc(); mem_ready = 1'b0;
        #1 chk("movb_madd", 32'(madd), 32'd2); chk("movb_xl", 32'(ram_xl), 32'd1);
        cyc(); chk("movb_hold", 32'(ram_xl), 32'd1);
        rst_n = 1'b0;
        #1 chk("movb_abort", 32'({ram_xl, madd}), 32'd0); chk("movb_rst", 32'(state), 32'd0);

        // IN and OUT with handshake stalls
        ir = 8'hD5; in_valid = 1'b0; mem_ready = 1'b1;
        cyc(); rst_n = 1'b1;
        wait_state(3'd3, 10);
        chk("in_stall", 32'({in_en, reg_we}), 32'b01);
        cyc(); chk("in_hold", 32'(state), 32'd3);
        in_valid = 1'b1;
        #1 chk("in_go", 32'({in_en, reg_we}), 32'b10);
        cyc(); chk("in_done", 32'(state), 32'd2); chk("in_ret", 32'(retired), 32'd1);
        ir = 8'hE5; in_valid = 1'b0; out_ready = 1'b0;
        cyc(); chk("out_exec", 32'(state), 32'd3);
        chk("out_stb", 32'({alu_m, shi_fbus, out_en}), 32'b111);
        cyc(); chk("out_hold", 32'(state), 32'd3);
        out_ready = 1'b1;
        cyc(); chk("out_done", 32'(state), 32'd2); chk("out_ret", 32'(retired), 32'd2);

        // Opcode sweep with randomised handshakes and flag changes during stalls
        for (int k = 0; k < 45; k++) begin
            wait_state(3'd2, 20);
            ir = {4'(k % 15), 4'($urandom)};
            z = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            mem_ready = 1'b1;
            cyc();
            for (int j = 0; j < 8 && state == 3'd3; j++) begin
                mem_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                z = 1'($urandom_range(0, 1));
                c = 1'($urandom_range(0, 1));
                if (j == 7) begin mem_ready = 1'b1; in_valid = 1'b1; out_ready = 1'b1; end
                cyc();
            end
            mem_ready = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
